motor3_gate_monitor: RTL and testbench

MOTOR3_GATE_MONITOR -- requirements
Module: motor3_gate_monitor

---
 rtl/motor3_pkg.sv | 30 +++
 rtl/motor3_phase_monitor.sv | 80 ++++++++
 rtl/motor3_gate_monitor.sv | 78 +++++++
 tb/tb_motor3_gate_monitor.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/motor3_pkg.sv
// Shared definitions for the three-phase gate-drive monitor: phase state
// encoding, default dead time and small decode helpers.
package motor3_pkg;

  localparam int DEAD_CYC_DEF = 2;
  localparam int CNT_W_DEF    = 16;

  // Encoding is {H, ~nL}, so the decode is a plain bit concatenation
  localparam logic [1:0] OFF     = 2'd0;
  localparam logic [1:0] DOWN    = 2'd1;
  localparam logic [1:0] UP      = 2'd2;
  localparam logic [1:0] ILLEGAL = 2'd3;

  function automatic logic [1:0] decodeState(input logic hin, input logic nLin);
    return {hin, ~nLin};
  endfunction

  function automatic logic isDriveState(input logic [1:0] st);
    return (st == DOWN) || (st == UP);
  endfunction

  function automatic logic [1:0] oppositeDrive(input logic [1:0] st);
    logic [1:0] opp;
    opp = OFF;
    if (st == DOWN) opp = UP;
    else if (st == UP) opp = DOWN;
    return opp;
  endfunction

endpackage

// File: rtl/motor3_phase_monitor.sv
// One phase of the gate monitor: captures the H/nL command pair, tracks dead
// time since the last drive, and raises sticky shoot-through / dead-time flags.
//
//   state   | meaning
//   OFF     | both switches off (H=0, nL=1)
//   DOWN    | low side on (H=0, nL=0)
//   UP      | high side on (H=1, nL=1)
//   ILLEGAL | both sides on (H=1, nL=0), shoot-through
module motor3_phase_monitor
  import motor3_pkg::*;
#(
  parameter int DEAD_CYC = DEAD_CYC_DEF
) (
  input  logic       clkI,
  input  logic       nRstI,
  input  logic       hinI,
  input  logic       nLinI,
  input  logic       clrFaultI,
  output logic [1:0] stateO,
  output logic       shootThruO,
  output logic       deadTimeErrO,
  output logic       entryO
);

  localparam int OFF_W = (DEAD_CYC < 1) ? 1 : $clog2(DEAD_CYC + 1);
  localparam logic [OFF_W-1:0] DEAD_MAX = OFF_W'(DEAD_CYC);

  logic             capH;
  logic             capNL;
  logic [1:0]       curState;
  logic [1:0]       prevState;
  logic [1:0]       lastDrv;
  logic [OFF_W-1:0] offCnt;
  logic             shootThru;
  logic             deadTimeErr;
  logic             isDrive;
  logic             entry;
  logic             violation;

  assign curState = decodeState(capH, capNL);
  assign isDrive  = isDriveState(curState);
  assign entry    = isDrive && (curState != prevState);

  // lastDrv is OFF after reset, so the first drive can never match the opposite
  assign violation = entry && (lastDrv == oppositeDrive(curState)) && (offCnt < DEAD_MAX);

  always_ff @(posedge clkI) begin
    if (!nRstI) begin
      capH        <= 1'b0;
      capNL       <= 1'b1;
      prevState   <= OFF;
      lastDrv     <= OFF;
      offCnt      <= DEAD_MAX;
      shootThru   <= 1'b0;
      deadTimeErr <= 1'b0;
    end else begin
      capH      <= hinI;
      capNL     <= nLinI;
      prevState <= curState;

      // Illegal is not off: it restarts the dead-time window like a drive
      if (curState == OFF) begin
        if (offCnt < DEAD_MAX) offCnt <= offCnt + OFF_W'(1);
      end else begin
        offCnt <= '0;
      end

      if (isDrive) lastDrv <= curState;

      shootThru   <= (shootThru & ~clrFaultI) | (curState == ILLEGAL);
      deadTimeErr <= (deadTimeErr & ~clrFaultI) | violation;
    end
  end

  assign stateO       = curState;
  assign shootThruO   = shootThru;
  assign deadTimeErrO = deadTimeErr;
  assign entryO       = entry;

endmodule

// File: rtl/motor3_gate_monitor.sv
// Three-phase gate-drive monitor: per-phase state decode and fault flags,
// plus a shared counter of drive-state entries across all phases.
module motor3_gate_monitor
  import motor3_pkg::*;
#(
  parameter int DEAD_CYC = DEAD_CYC_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic             clkI,
  input  logic             nRstI,
  input  logic             aHinI,
  input  logic             bHinI,
  input  logic             cHinI,
  input  logic             aNLinI,
  input  logic             bNLinI,
  input  logic             cNLinI,
  input  logic             clrFaultI,
  output logic [1:0]       aStateO,
  output logic [1:0]       bStateO,
  output logic [1:0]       cStateO,
  output logic [2:0]       shootThruO,
  output logic [2:0]       deadTimeErrO,
  output logic             faultO,
  output logic [CNT_W-1:0] stepCntO
);

  logic [2:0]       entry;
  logic [1:0]       stepInc;
  logic [CNT_W-1:0] stepCnt;

  motor3_phase_monitor #(.DEAD_CYC(DEAD_CYC)) uPhaseA (
    .clkI        (clkI),
    .nRstI       (nRstI),
    .hinI        (aHinI),
    .nLinI       (aNLinI),
    .clrFaultI   (clrFaultI),
    .stateO      (aStateO),
    .shootThruO  (shootThruO[0]),
    .deadTimeErrO(deadTimeErrO[0]),
    .entryO      (entry[0])
  );

  motor3_phase_monitor #(.DEAD_CYC(DEAD_CYC)) uPhaseB (
    .clkI        (clkI),
    .nRstI       (nRstI),
    .hinI        (bHinI),
    .nLinI       (bNLinI),
    .clrFaultI   (clrFaultI),
    .stateO      (bStateO),
    .shootThruO  (shootThruO[1]),
    .deadTimeErrO(deadTimeErrO[1]),
    .entryO      (entry[1])
  );

  motor3_phase_monitor #(.DEAD_CYC(DEAD_CYC)) uPhaseC (
    .clkI        (clkI),
    .nRstI       (nRstI),
    .hinI        (cHinI),
    .nLinI       (cNLinI),
    .clrFaultI   (clrFaultI),
    .stateO      (cStateO),
    .shootThruO  (shootThruO[2]),
    .deadTimeErrO(deadTimeErrO[2]),
    .entryO      (entry[2])
  );

  assign stepInc = 2'(entry[0]) + 2'(entry[1]) + 2'(entry[2]);

  // Free-running wrap is intended; the count is a commutation odometer
  always_ff @(posedge clkI) begin
    if (!nRstI) stepCnt <= '0;
    else        stepCnt <= stepCnt + CNT_W'(stepInc);
  end

  assign stepCntO = stepCnt;
  assign faultO   = |{shootThruO, deadTimeErrO};

endmodule

// File: tb/tb_motor3_gate_monitor.sv
// Self-checking bench for motor3_gate_monitor: directed scenarios plus random
// gate commands compared against a run-length based reference model.
module tb_motor3_gate_monitor;

  localparam int DEAD = 2;

  logic        clkI = 1'b0;
  logic        nRstI;
  logic        clrFaultI;
  logic [2:0]  hIn;
  logic [2:0]  nlIn;
  logic [1:0]  aStateO, bStateO, cStateO;
  logic [2:0]  shootThruO, deadTimeErrO;
  logic        faultO;
  logic [15:0] stepCntO;

  wire [28:0] obsVec = {aStateO, bStateO, cStateO, shootThruO, deadTimeErrO, faultO, stepCntO};

  int testCnt = 0;
  int failCnt = 0;

  // Reference model: states as ints 0 off, 1 down, 2 up, 3 illegal
  int          mCap[3];
  int          mPrev[3];
  int          mOffRun[3];
  int          mLastDrv[3];
  bit          mSt[3];
  bit          mDt[3];
  int unsigned mCnt;

  always #5 clkI = ~clkI;

  motor3_gate_monitor #(.DEAD_CYC(DEAD), .CNT_W(16)) dut (
    .clkI        (clkI),
    .nRstI       (nRstI),
    .aHinI       (hIn[0]),
    .bHinI       (hIn[1]),
    .cHinI       (hIn[2]),
    .aNLinI      (nlIn[0]),
    .bNLinI      (nlIn[1]),
    .cNLinI      (nlIn[2]),
    .clrFaultI   (clrFaultI),
    .aStateO     (aStateO),
    .bStateO     (bStateO),
    .cStateO     (cStateO),
    .shootThruO  (shootThruO),
    .deadTimeErrO(deadTimeErrO),
    .faultO      (faultO),
    .stepCntO    (stepCntO)
  );

  function automatic int stateOf(input logic h, input logic nl);
    if (h) return nl ? 2 : 3;
    return nl ? 0 : 1;
  endfunction

  task automatic modelEdge();
    int ent;
    ent = 0;
    if (!nRstI) begin
      for (int p = 0; p < 3; p++) begin
        mCap[p] = 0; mPrev[p] = 0; mOffRun[p] = 1000; mLastDrv[p] = 0;
        mSt[p] = 0; mDt[p] = 0;
      end
      mCnt = 0;
      return;
    end
    for (int p = 0; p < 3; p++) begin
      int  s;
      bit  drive, enter, viol;
      s     = mCap[p];
      drive = (s == 1) || (s == 2);
      enter = drive && (s != mPrev[p]);
      viol  = enter && (mLastDrv[p] != 0) && (mLastDrv[p] != s) && (mOffRun[p] < DEAD);
      mSt[p] = (mSt[p] && !clrFaultI) || (s == 3);
      mDt[p] = (mDt[p] && !clrFaultI) || viol;
      if (enter) ent++;
      if (s == 0) begin
        if (mOffRun[p] < 1000) mOffRun[p]++;
      end else begin
        mOffRun[p] = 0;
      end
      if (drive) mLastDrv[p] = s;
      mPrev[p] = s;
      mCap[p]  = stateOf(hIn[p], nlIn[p]);
    end
    mCnt = (mCnt + ent) % 65536;
  endtask

  function automatic logic [28:0] expVec();
    logic [2:0] st;
    logic [2:0] dt;
    for (int p = 0; p < 3; p++) begin
      st[p] = mSt[p];
      dt[p] = mDt[p];
    end
    return {2'(mCap[0]), 2'(mCap[1]), 2'(mCap[2]), st, dt, |{st, dt}, 16'(mCnt)};
  endfunction

  task automatic tick();
    @(posedge clkI);
    modelEdge();
    #1;
  endtask

  task automatic setPhase(input int p, input int st);
    case (st)
      0:       begin hIn[p] = 1'b0; nlIn[p] = 1'b1; end
      1:       begin hIn[p] = 1'b0; nlIn[p] = 1'b0; end
      2:       begin hIn[p] = 1'b1; nlIn[p] = 1'b1; end
      default: begin hIn[p] = 1'b1; nlIn[p] = 1'b0; end
    endcase
  endtask

  task automatic doReset();
    hIn = 3'b000; nlIn = 3'b111; clrFaultI = 1'b0; nRstI = 1'b0;
    tick(); tick();
    nRstI = 1'b1;
  endtask

  task automatic test_reset();
    nRstI = 1'b0; clrFaultI = 1'b1;
    hIn = 3'b101; nlIn = 3'b100;
    tick(); tick();
    testCnt++;
    if (obsVec !== 29'd0) begin
      failCnt++; $display("FAIL reset_values: got %h want 0", obsVec);
    end
    testCnt++;
    if (obsVec !== expVec()) begin
      failCnt++; $display("FAIL reset_model: got %h want %h", obsVec, expVec());
    end
    doReset();
  endtask

  task automatic test_clean_commutation();
    int seqA[9] = '{1, 1, 1, 1, 1, 0, 0, 2, 2};
    doReset();
    tick();
    for (int i = 0; i < 9; i++) begin
      setPhase(0, seqA[i]);
      tick();
      testCnt++;
      if (aStateO !== 2'(seqA[i]) || obsVec !== expVec()) begin
        failCnt++;
        $display("FAIL clean_step%0d: aState %0d want %0d, vec %h want %h", i, aStateO, seqA[i], obsVec, expVec());
      end
    end
    tick();
    testCnt++;
    if (deadTimeErrO !== 3'b000 || stepCntO !== 16'd2) begin
      failCnt++; $display("FAIL clean_end: dt %b cnt %0d want dt 000 cnt 2", deadTimeErrO, stepCntO);
    end
  endtask

  task automatic test_dead_time();
    int seqA[5] = '{1, 1, 1, 0, 2};
    doReset();
    for (int i = 0; i < 5; i++) begin
      setPhase(0, seqA[i]);
      tick();
      testCnt++;
      if (obsVec !== expVec()) begin
        failCnt++; $display("FAIL dead_step%0d: got %h want %h", i, obsVec, expVec());
      end
    end
    testCnt++;
    if (deadTimeErrO[0] !== 1'b0) begin
      failCnt++; $display("FAIL dead_early: dt0 %b want 0", deadTimeErrO[0]);
    end
    tick();
    testCnt++;
    if (deadTimeErrO[0] !== 1'b1 || faultO !== 1'b1 || stepCntO !== 16'd2) begin
      failCnt++;
      $display("FAIL dead_flag: dt0 %b fault %b cnt %0d want 1 1 2", deadTimeErrO[0], faultO, stepCntO);
    end
  endtask

  task automatic test_shoot_thru();
    doReset();
    setPhase(1, 3);
    tick();
    setPhase(1, 0);
    testCnt++;
    if (bStateO !== 2'd3 || shootThruO[1] !== 1'b0) begin
      failCnt++; $display("FAIL st_decode: bState %0d st %b want 3 0", bStateO, shootThruO[1]);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      testCnt++;
      if (bStateO !== 2'd0 || shootThruO[1] !== 1'b1 || obsVec !== expVec()) begin
        failCnt++;
        $display("FAIL st_sticky%0d: bState %0d st %b vec %h want 0 1 %h", i, bStateO, shootThruO[1], obsVec, expVec());
      end
    end
    clrFaultI = 1'b1;
    tick();
    clrFaultI = 1'b0;
    testCnt++;
    if (shootThruO !== 3'b000 || faultO !== 1'b0 || obsVec !== expVec()) begin
      failCnt++; $display("FAIL st_clear: st %b fault %b want 000 0", shootThruO, faultO);
    end
  endtask

  task automatic test_clear_collision();
    doReset();
    setPhase(0, 3);
    setPhase(2, 1);
    tick();
    setPhase(0, 0);
    tick();
    setPhase(2, 2);
    tick();
    clrFaultI = 1'b1;
    tick();
    clrFaultI = 1'b0;
    testCnt++;
    if (deadTimeErrO[2] !== 1'b1 || shootThruO[0] !== 1'b0 || obsVec !== expVec()) begin
      failCnt++;
      $display("FAIL clr_collision: dt2 %b st0 %b vec %h want 1 0 %h", deadTimeErrO[2], shootThruO[0], obsVec, expVec());
    end
  endtask

  task automatic test_wrap();
    doReset();
    setPhase(0, 2); setPhase(1, 2); setPhase(2, 0);
    tick();
    for (int i = 1; i <= 21844; i++) begin
      for (int p = 0; p < 3; p++) setPhase(p, (i % 2 == 1) ? 1 : 2);
      tick();
    end
    for (int p = 0; p < 3; p++) setPhase(p, 1);
    tick();
    testCnt++;
    if (stepCntO !== 16'hFFFE || obsVec !== expVec()) begin
      failCnt++; $display("FAIL wrap_pre: cnt %h want fffe, vec %h want %h", stepCntO, obsVec, expVec());
    end
    tick();
    testCnt++;
    if (stepCntO !== 16'h0001 || obsVec !== expVec()) begin
      failCnt++; $display("FAIL wrap_post: cnt %h want 0001, vec %h want %h", stepCntO, obsVec, expVec());
    end
  endtask

  task automatic test_reset_mid();
    doReset();
    setPhase(0, 2); setPhase(1, 3); setPhase(2, 1);
    tick();
    setPhase(1, 0); setPhase(2, 2);
    tick(); tick(); tick();
    testCnt++;
    if (faultO !== 1'b1 || aStateO !== 2'd2) begin
      failCnt++; $display("FAIL mid_setup: fault %b aState %0d want 1 2", faultO, aStateO);
    end
    nRstI = 1'b0;
    setPhase(0, 1); setPhase(2, 0);
    tick();
    testCnt++;
    if (obsVec !== 29'd0) begin
      failCnt++; $display("FAIL mid_reset: got %h want 0", obsVec);
    end
    nRstI = 1'b1;
    tick();
    testCnt++;
    if (aStateO !== 2'd1) begin
      failCnt++; $display("FAIL mid_down: aState %0d want 1", aStateO);
    end
    tick();
    testCnt++;
    if (deadTimeErrO !== 3'b000 || stepCntO !== 16'd1 || obsVec !== expVec()) begin
      failCnt++; $display("FAIL mid_after: dt %b cnt %0d want 000 1", deadTimeErrO, stepCntO);
    end
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    doReset();
    for (int i = 0; i < 800; i++) begin
      for (int p = 0; p < 3; p++) begin
        if ($urandom_range(0, 1) == 1) begin
          int r;
          r = $urandom_range(0, 15);
          setPhase(p, (r == 0) ? 3 : (r % 3));
        end
      end
      clrFaultI = ($urandom_range(0, 19) == 0);
      nRstI     = ($urandom_range(0, 59) != 0);
      tick();
      testCnt++;
      if (obsVec !== expVec()) begin
        failCnt++;
        errs++;
        if (errs <= 10) $display("FAIL random_cyc%0d: got %h want %h", i, obsVec, expVec());
      end
    end
    nRstI = 1'b1;
    clrFaultI = 1'b0;
  endtask

  initial begin
    nRstI = 1'b0; clrFaultI = 1'b0; hIn = 3'b000; nlIn = 3'b111;
    for (int p = 0; p < 3; p++) begin
      mCap[p] = 0; mPrev[p] = 0; mOffRun[p] = 1000; mLastDrv[p] = 0;
      mSt[p] = 0; mDt[p] = 0;
    end
    mCnt = 0;
    test_reset();
    test_clean_commutation();
    test_dead_time();
    test_shoot_thru();
    test_clear_collision();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
    $finish;
  end

endmodule
